// File: rtl/tdm_demux_1x4.sv
// tdm_demux_1x4: receive-side time-division demultiplexer.
// A 2-bit slot counter, aligned by a frame-sync marker, steers each valid
// beat of an interleaved stream into one of four channels. The four channel
// outputs are updated together once per complete frame.
module tdm_demux_1x4 #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    input  logic         i_sync,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_ch0,
    output logic [W-1:0] o_ch1,
    output logic [W-1:0] o_ch2,
    output logic [W-1:0] o_ch3,
    output logic         o_frame_valid,
    output logic         o_locked,
    output logic [1:0]   o_slot,
    output logic         o_err
);

    localparam logic [0:0] S_HUNT   = 1'b0;
    localparam logic [0:0] S_LOCKED = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [W-1:0] stg0_q, stg0_d;
    logic [W-1:0] stg1_q, stg1_d;
    logic [W-1:0] stg2_q, stg2_d;
    logic [W-1:0] ch0_q, ch0_d;
    logic [W-1:0] ch1_q, ch1_d;
    logic [W-1:0] ch2_q, ch2_d;
    logic [W-1:0] ch3_q, ch3_d;
    logic         frame_valid_q, frame_valid_d;
    logic         err_q, err_d;

    // Next-state logic: framing FSM, slot counter, staging and frame commit.
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no
        // path leaves it unassigned; a missing default infers a latch.
        state_d       = state_q;
        slot_d        = slot_q;
        stg0_d        = stg0_q;
        stg1_d        = stg1_q;
        stg2_d        = stg2_q;
        ch0_d         = ch0_q;
        ch1_d         = ch1_q;
        ch2_d         = ch2_q;
        ch3_d         = ch3_q;
        frame_valid_d = 1'b0;
        err_d         = 1'b0;

        // Idle cycles (i_valid low) leave every register untouched.
        if (i_valid) begin
            case (state_q)
                S_HUNT: begin
                    // Only a sync beat can start a frame; others are dropped.
                    if (i_sync) begin
                        stg0_d  = i_data;
                        slot_d  = 2'd1;
                        state_d = S_LOCKED;
                    end
                end
                default: begin
                    if (i_sync && (slot_q != 2'd0)) begin
                        // Misaligned sync: abandon the partial frame and
                        // restart with this beat as slot 0.
                        err_d  = 1'b1;
                        stg0_d = i_data;
                        slot_d = 2'd1;
                    end else begin
                        case (slot_q)
                            2'd0: stg0_d = i_data;
                            2'd1: stg1_d = i_data;
                            2'd2: stg2_d = i_data;
                            default: begin
                                // Slot 3 completes the frame: all four
                                // channels update in the same edge.
                                ch0_d         = stg0_q;
                                ch1_d         = stg1_q;
                                ch2_d         = stg2_q;
                                ch3_d         = i_data;
                                frame_valid_d = 1'b1;
                            end
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                end
            endcase
        end
    end

    // State registers with synchronous reset, which wins over all inputs.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            // NOTE: staging and channel registers are cleared too, because
            // their reset contents are visible on the outputs.
            state_q       <= S_HUNT;
            slot_q        <= 2'd0;
            stg0_q        <= '0;
            stg1_q        <= '0;
            stg2_q        <= '0;
            ch0_q         <= '0;
            ch1_q         <= '0;
            ch2_q         <= '0;
            ch3_q         <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            stg0_q        <= stg0_d;
            stg1_q        <= stg1_d;
            stg2_q        <= stg2_d;
            ch0_q         <= ch0_d;
            ch1_q         <= ch1_d;
            ch2_q         <= ch2_d;
            ch3_q         <= ch3_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    assign o_ch0         = ch0_q;
    assign o_ch1         = ch1_q;
    assign o_ch2         = ch2_q;
    assign o_ch3         = ch3_q;
    assign o_frame_valid = frame_valid_q;
    assign o_locked      = (state_q == S_LOCKED);
    assign o_slot        = slot_q;
    assign o_err         = err_q;

endmodule

// File: doc/tdm_demux_1x4.md
# tdm_demux_1x4

Time-division demultiplexer that recovers four channels from a single slot-interleaved stream, the receive-side counterpart of the 4:1 multiplexer. A 2-bit slot counter plays the role of the mux select. It is aligned by a frame-sync marker and steers each valid beat into a per-channel register. All four channel outputs update together once per complete frame, so downstream logic sees a coherent 4-channel sample set.

## Interface
- `W`, default 8: data width of the stream and of each channel.
- `i_clk` input, 1 bit: clock; all state updates on the rising edge.
- `i_rst` input, 1 bit: synchronous reset, active-high.
- `i_valid` input, 1 bit: a beat is present on `i_data` this cycle.
- `i_sync` input, 1 bit: marks the current beat as slot 0. Ignored when `i_valid`=0.
- `i_data` input, W bits: stream data.
- `o_ch0`..`o_ch3` output, W bits each: last complete frame, slots 0..3.
- `o_frame_valid` output, 1 bit: one-cycle pulse when `o_ch0`..`o_ch3` have just been updated.
- `o_locked` output, 1 bit: high while the FSM is in LOCKED.
- `o_slot` output, 2 bits: slot index the next valid beat will occupy.
- `o_err` output, 1 bit: one-cycle pulse on a sync misalignment.

## Operation
- **FSM states.** HUNT and LOCKED.
- **HUNT.**
  - Valid beats without sync are discarded.
  - A valid beat with `i_sync`=1 is stored as slot 0, sets the counter to 1, and moves the FSM to LOCKED.
- **LOCKED.** Each valid beat is stored into slot `o_slot`; the counter then increments modulo 4 (3 wraps to 0).
- **Sync on slot 0.** In LOCKED, sync is optional on slot-0 beats. A slot-0 beat without sync is accepted (free-running frames).
- **Sync misalignment.** A valid beat with `i_sync`=1 while the counter is not 0:
  - `o_err` pulses.
  - The partial frame is discarded and no `o_frame_valid` is issued for it.
  - The beat is stored as slot 0 of a new frame and the counter is set to 1.
  - The FSM stays LOCKED.
- **Staging.**
  - Slots 0..2 are captured into internal staging registers.
  - On the slot-3 beat, `o_ch0`..`o_ch2` load from staging and `o_ch3` loads from `i_data` in the same edge.
  - `o_frame_valid` is set for exactly one cycle.
- **Channel outputs.** `o_ch*` hold their value between frames. They change only together with an `o_frame_valid` pulse.
- **Idle cycles.** A cycle with `i_valid`=0 changes no state: no counter advance and no staging write. Gaps inside a frame are allowed.
- **Reset values** (forced by `i_rst`=1 on a clock edge):
  - FSM in HUNT, counter 0, staging registers 0.
  - `o_ch0`..`o_ch3` = 0.
  - `o_frame_valid`, `o_err`, `o_locked` = 0 and `o_slot` = 0.
- **Reset mid-frame.** The partial frame is dropped. The next frame requires a new sync.
- **Reset priority.** `i_rst` has priority over every other input in the same cycle.

## Timing
- **Registered outputs.** All outputs are registered; no combinational path runs from any input to any output.
- **Frame latency.** The slot-3 beat at edge N makes `o_ch*` and `o_frame_valid` visible after edge N, i.e. one cycle of latency.
- **Error timing.**
  - `o_err` is visible the cycle after the misaligned sync beat.
  - `o_slot` reads 1 in that same cycle.
- **Lock timing.** `o_locked` rises the cycle after the first sync beat accepted in HUNT.
- **Throughput.** One beat per cycle sustained, so back-to-back frames give an `o_frame_valid` pulse every 4 cycles. No backpressure exists; the stream is never stalled.
- **Sync on slot-3 cycle.** A sync at counter 3 is a misalignment. The frame does not complete, `o_err` pulses, and `o_frame_valid` stays low.

## Test plan
- **Reset state:** assert `i_rst` for 2 cycles with random inputs -> all outputs 0, `o_locked`=0, `o_slot`=0.
- **Clean frames:** W=8; beats 0x11(sync), 0x22, 0x33, 0x44, then 0xA1(sync), 0xA2, 0xA3, 0xA4 back-to-back -> `o_ch0..3`=11/22/33/44 with a one-cycle `o_frame_valid` after the 4th beat, then A1/A2/A3/A4 exactly 4 cycles later.
- **HUNT discard:** beats 0x55, 0x66 without sync, then a clean frame 0x01(sync), 0x02, 0x03, 0x04 -> 0x55/0x66 never appear; `o_locked` rises the cycle after the 0x01 beat; output is 01/02/03/04.
- **Gaps:** insert `i_valid`=0 cycles between every beat of frame 0x10(sync)..0x13 -> same outputs as without gaps; `o_slot` holds during gaps; a single `o_frame_valid` after 0x13.
- **Misalignment:** after 0x21(sync), 0x22, send 0x31 with sync, then 0x32, 0x33, 0x34 -> `o_err` pulses once; no frame with 0x21; next output 31/32/33/34.
- **Reset mid-frame:** 0x41(sync), 0x42, then `i_rst` for 1 cycle, then 0x43, 0x44 without sync -> outputs stay 0, no `o_frame_valid`, `o_locked`=0.
